// File: rtl/result_sram_reader_pkg.sv
// ---------------------------------------------------------------------------
// result_sram_reader_pkg
//   Shared definitions for the ResultSRAM read-back block: default SRAM
//   geometry, the read-back FSM state encoding and the tag that travels with
//   every SRAM read so that each pixel leaves with its own coordinates.
// ---------------------------------------------------------------------------
package result_sram_reader_pkg;

    localparam int AW_DEF = 14;  // ResultSRAM address width
    localparam int DW_DEF = 8;   // pixel width
    localparam int CW     = 6;   // row/column index width (images up to 63x63)

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    // Coordinates of one pixel; carried alongside its SRAM read.
    typedef struct packed {
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic          last;
    } pix_tag_t;

endpackage

// File: rtl/result_sram_reader_rd_fifo2.sv
// ---------------------------------------------------------------------------
// rd_fifo2
//   Two-entry FIFO of {pixel data, pixel tag}. Slot 0 is always the head, so
//   the head outputs come straight from a register and stay stable while the
//   sink stalls. Push and pop may happen in the same cycle, including when
//   the FIFO is full.
//
// Ports
//   CLK, RST_N   clock, asynchronous active-low reset
//   push         write push_data/push_tag this cycle
//   push_data    pixel value to store
//   push_tag     row/col/last of that pixel
//   pop          remove the head entry this cycle
//   head_data    data of the head entry
//   head_tag     tag of the head entry
//   head_valid   FIFO holds at least one entry
//   count        number of entries held (0..2)
// ---------------------------------------------------------------------------
module rd_fifo2
    import result_sram_reader_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  pix_tag_t      push_tag,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output pix_tag_t      head_tag,
    output logic          head_valid,
    output logic [1:0]    count
);

    logic [DW-1:0] data_q [2];
    pix_tag_t      tag_q  [2];
    logic [1:0]    count_q;

    logic do_pop;
    logic do_push;
    logic wr_idx;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);
    // Slot written is the occupancy left after this cycle's pop.
    assign wr_idx  = (count_q - {1'b0, do_pop}) != 2'd0;

    // NOTE: the storage is reset as well, because the head slot drives the
    // pixel outputs directly and those must read zero out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            count_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments; when a pop shifts slot 1 down and
            // a push lands in slot 0 in the same cycle, the later push wins.
            if (do_pop) begin
                data_q[0] <= data_q[1];
                tag_q[0]  <= tag_q[1];
            end
            if (do_push) begin
                data_q[wr_idx] <= push_data;
                tag_q[wr_idx]  <= push_tag;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data  = data_q[0];
    assign head_tag   = tag_q[0];
    assign head_valid = (count_q != 2'd0);
    assign count      = count_q;

endmodule

// File: rtl/result_sram_reader.sv
// ---------------------------------------------------------------------------
// result_sram_reader
//   Streams the TW x TH result image out of ResultSRAM in row-major order over
//   a valid/ready pixel interface, once START is pulsed. The block is the sole
//   SRAM master while BUSY. A 2-entry FIFO absorbs the 1-cycle SRAM latency so
//   that, with the sink always ready, one pixel transfers per cycle.
//
// Ports
//   CLK, RST_N   clock, asynchronous active-low reset
//   START        1-cycle pulse, begins a read-back (ignored while BUSY)
//   TW, TH       image width/height, sampled at START
//   CEN, WEN     SRAM chip/write enable, active low (WEN held high)
//   A            SRAM address
//   Q            SRAM read data, valid the cycle after CEN=0
//   PIX_DATA     head pixel value
//   PIX_ROW/COL  coordinates of PIX_DATA
//   PIX_LAST     PIX_DATA is pixel (TH-1, TW-1)
//   PIX_VALID    head pixel valid
//   PIX_READY    sink accepts the head pixel
//   BUSY         read-back in progress
//   DONE         1-cycle pulse after the last pixel has transferred
// ---------------------------------------------------------------------------
module result_sram_reader
    import result_sram_reader_pkg::*;
#(
    parameter int            AW   = AW_DEF,
    parameter int            DW   = DW_DEF,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [CW-1:0] TW,
    input  logic [CW-1:0] TH,
    output logic          CEN,
    output logic          WEN,
    output logic [AW-1:0] A,
    input  logic [DW-1:0] Q,
    output logic [DW-1:0] PIX_DATA,
    output logic [CW-1:0] PIX_ROW,
    output logic [CW-1:0] PIX_COL,
    output logic          PIX_LAST,
    output logic          PIX_VALID,
    input  logic          PIX_READY,
    output logic          BUSY,
    output logic          DONE
);

    state_t        state_q, state_d;

    logic [CW-1:0] tw_q, th_q;
    logic [AW-1:0] addr_q;       // next address to read
    logic [CW-1:0] row_q, col_q; // coordinates of that address
    logic          inflight_q;   // a read was issued last cycle; Q arrives now
    pix_tag_t      inflight_tag_q;

    logic [CW-1:0] cur_tw, cur_th;
    logic          size_ok;
    logic          issue_last;
    logic          issue;
    logic          pop;
    logic          credit_ok;
    logic [2:0]    occupancy;
    logic [1:0]    fifo_count;
    pix_tag_t      head_tag;

    // The very first read goes out in the START cycle itself, straight from the
    // live TW/TH; afterwards the latched copies are used. This is what gives
    // the two-cycle START-to-first-pixel latency.
    assign cur_tw     = (state_q == IDLE) ? TW : tw_q;
    assign cur_th     = (state_q == IDLE) ? TH : th_q;
    assign size_ok    = (TW != '0) && (TH != '0);
    assign issue_last = (row_q == cur_th - 1'b1) && (col_q == cur_tw - 1'b1);

    assign pop        = PIX_VALID && PIX_READY;
    // Entries that will be held once this cycle's pop and the in-flight read
    // have landed; a new read may go out only if that leaves room for it.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok  = (occupancy < 3'd2);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    if (!size_ok)        state_d = FIN;
                    else if (issue_last) state_d = DRAIN;  // 1x1: only read already issued
                    else                 state_d = READ;
                end
            end
            READ: begin
                if (issue && issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave as soon as the FIFO is empty after this cycle's pop.
                if (!inflight_q && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop)))
                    state_d = FIN;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue = 1'b0;
        unique case (state_q)
            IDLE:    issue = START && size_ok;
            READ:    issue = credit_ok;
            default: issue = 1'b0;
        endcase
        CEN  = !issue;
        WEN  = 1'b1;
        A    = issue ? addr_q : '0;
        BUSY = (state_q != IDLE);
        DONE = (state_q == FIN);
    end

    // ---------------- address / coordinate counters ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tw_q           <= '0;
            th_q           <= '0;
            addr_q         <= BASE;
            row_q          <= '0;
            col_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
        end else begin
            inflight_q <= issue;
            if (state_q == IDLE && START) begin
                tw_q <= TW;
                th_q <= TH;
            end
            if (issue) begin
                inflight_tag_q <= '{row: row_q, col: col_q, last: issue_last};
                addr_q         <= addr_q + 1'b1;
                if (col_q == cur_tw - 1'b1) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else if (state_q == FIN) begin
                addr_q <= BASE;
                row_q  <= '0;
                col_q  <= '0;
            end
        end
    end

    // ---------------- output FIFO ----------------
    rd_fifo2 #(.DW(DW)) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (inflight_q),
        .push_data  (Q),
        .push_tag   (inflight_tag_q),
        .pop        (pop),
        .head_data  (PIX_DATA),
        .head_tag   (head_tag),
        .head_valid (PIX_VALID),
        .count      (fifo_count)
    );

    assign PIX_ROW  = head_tag.row;
    assign PIX_COL  = head_tag.col;
    assign PIX_LAST = head_tag.last;

endmodule
